multicycle_control_fsm: RTL

- Control unit for the multicycle RISC-V core: one shared ALU, one unified instruction/data memory, one register file.
- Replaces the single-cycle combinational main decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds a memory ready handshake and sticky illegal-opcode detection.
- Contains the ALU-control decode, so it drives the whole datapath directly.

---
 rtl/multicycle_control_fsm.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control unit: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, with ready handshake and sticky illegal flag.
module multicycle_control_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic       pc_update, branch, ir_write, mem_write, reg_write, done;
    logic       adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_IALU:      state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = ILLEGAL;
                endcase
            end
            MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (mem_ready) state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            ILLEGAL:  state_d = ILLEGAL;
            default:  state_d = FETCH;
        endcase
        illegal_d = illegal_q | (state_d == ILLEGAL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= state_t'(RESET_STATE);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore decode of state; the few handshake-dependent strobes are qualified below
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        done       = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                done       = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                done      = mem_ready;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            ALUWB: begin
                reg_write = 1'b1;
                done      = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alu_op)
            2'b01:   ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Reset gates the strobes directly so nothing fires in the asynchronous reset window
    assign PCWrite    = ~reset & (pc_update | (branch & Zero));
    assign IRWrite    = ~reset & ir_write;
    assign MemWrite   = ~reset & mem_write;
    assign RegWrite   = ~reset & reg_write;
    assign instr_done = ~reset & done;
    assign AdrSrc     = adr_src;
    assign ResultSrc  = result_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign illegal    = illegal_q;

endmodule
